// File: rtl/sign_mag_bcd_decoder_pkg.sv
// sign_mag_bcd_decoder_pkg
//   Shared constants and types for the sign/magnitude BCD decoder.
//   NEG_CODE_DEF / BLANK_CODE_DEF are the same nibble codes used by the
//   subtractor and display driver. The FSM encoding and the double-dabble
//   iteration count live here too.
package sign_mag_bcd_decoder_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t NEG_CODE_DEF   = 4'b1010;
    localparam nibble_t BLANK_CODE_DEF = 4'b1111;

    // One shift/add-3 step per magnitude bit.
    localparam int unsigned ITERATIONS = 8;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sign_mag_bcd_decoder_if.sv
// sign_mag_bcd_decoder_if
//   Request/result bundle between the subtractor-side producer (master) and
//   the decoder (slave).
//   master -> slave : start, magnitude[7:0], sign_code[3:0]
//   slave -> master : busy, done, err, digit_sign/hund/tens/ones[3:0]
interface sign_mag_bcd_decoder_if;
    import sign_mag_bcd_decoder_pkg::*;

    logic       start;
    logic [7:0] magnitude;
    nibble_t    sign_code;
    logic       busy;
    logic       done;
    logic       err;
    nibble_t    digit_sign;
    nibble_t    digit_hund;
    nibble_t    digit_tens;
    nibble_t    digit_ones;

    modport master (
        output start, magnitude, sign_code,
        input  busy, done, err, digit_sign, digit_hund, digit_tens, digit_ones
    );

    modport slave (
        input  start, magnitude, sign_code,
        output busy, done, err, digit_sign, digit_hund, digit_tens, digit_ones
    );

endinterface

// File: rtl/sign_mag_bcd_decoder_bcd_add3.sv
// bcd_add3
//   Double-dabble correction cell: adds 3 to a BCD nibble that is >= 5 so
//   the following left shift carries correctly into the next decade.
//   i_nib : nibble before correction
//   o_nib : corrected nibble (never exceeds 4'hC for legal BCD input)
module bcd_add3
    import sign_mag_bcd_decoder_pkg::*;
(
    input  nibble_t i_nib,
    output nibble_t o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule

// File: rtl/sign_mag_bcd_decoder.sv
// sign_mag_bcd_decoder
//   Converts an 8-bit magnitude plus 4-bit sign code into four display
//   nibbles (sign, hundreds, tens, ones) using an iterative double-dabble,
//   one bit per clock, with optional leading-zero blanking.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : slave side of sign_mag_bcd_decoder_if (start/magnitude/sign_code
//           in; busy/done/err/digit_* out)
module sign_mag_bcd_decoder
    import sign_mag_bcd_decoder_pkg::*;
#(
    parameter nibble_t NEG_CODE   = NEG_CODE_DEF,
    parameter nibble_t BLANK_CODE = BLANK_CODE_DEF,
    parameter bit      LZ_BLANK   = 1'b1
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    sign_mag_bcd_decoder_if.slave bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_mag;
    logic [11:0]      r_bcd;
    logic             r_neg;
    logic             r_inv;
    logic             r_err;
    nibble_t          r_dsign;
    nibble_t          r_dhund;
    nibble_t          r_dtens;
    nibble_t          r_dones;

    logic             w_accept;
    logic             w_last;
    logic [11:0]      w_adj;
    logic [19:0]      w_shift;
    logic [11:0]      w_bcd_next;
    nibble_t          w_hund;
    nibble_t          w_tens;
    nibble_t          w_ones;
    logic             w_blank_hund;
    logic             w_blank_tens;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(ITERATIONS - 1));

    bcd_add3 u_add3_hund (.i_nib(r_bcd[11:8]), .o_nib(w_adj[11:8]));
    bcd_add3 u_add3_tens (.i_nib(r_bcd[7:4]),  .o_nib(w_adj[7:4]));
    bcd_add3 u_add3_ones (.i_nib(r_bcd[3:0]),  .o_nib(w_adj[3:0]));

    assign w_shift    = {w_adj, r_mag} << 1;
    assign w_bcd_next = w_shift[19:8];
    assign w_hund     = w_bcd_next[11:8];
    assign w_tens     = w_bcd_next[7:4];
    assign w_ones     = w_bcd_next[3:0];

    // Tens is only blanked when hundreds is blanked too, so 105 shows "105".
    assign w_blank_hund = LZ_BLANK && (w_hund == 4'h0);
    assign w_blank_tens = w_blank_hund && (w_tens == 4'h0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_inv   <= 1'b0;
            r_err   <= 1'b0;
            r_dsign <= BLANK_CODE;
            r_dhund <= BLANK_CODE;
            r_dtens <= BLANK_CODE;
            r_dones <= 4'h0;
        end else if (w_accept) begin
            r_mag <= bus.magnitude;
            r_bcd <= '0;
            r_cnt <= '0;
            // Sign is resolved at capture; negative zero folds to positive.
            r_neg <= (bus.sign_code == NEG_CODE) && (bus.magnitude != 8'd0);
            r_inv <= (bus.sign_code != 4'h0) && (bus.sign_code != NEG_CODE);
        end else if (r_state == ST_SHIFT) begin
            r_bcd <= w_bcd_next;
            r_mag <= w_shift[7:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_err   <= r_inv;
                r_dsign <= r_neg ? NEG_CODE : BLANK_CODE;
                r_dhund <= w_blank_hund ? BLANK_CODE : w_hund;
                r_dtens <= w_blank_tens ? BLANK_CODE : w_tens;
                r_dones <= w_ones;
            end
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = r_err;
    assign bus.digit_sign = r_dsign;
    assign bus.digit_hund = r_dhund;
    assign bus.digit_tens = r_dtens;
    assign bus.digit_ones = r_dones;

endmodule
